// File: rtl/dwrr_req_queues_if.sv
// Source/arbiter/output signal bundle for dwrr_req_queues.
// slave = the queue block, master = whatever drives sources, grants and stall.
interface dwrr_req_queues_if #(
  parameter int NUM_REQS = 4,
  parameter int DWID     = 8,
  parameter int CNTWID   = $clog2(NUM_REQS)
);
  logic [NUM_REQS-1:0]      push;
  logic [NUM_REQS*DWID-1:0] push_data;
  logic [NUM_REQS-1:0]      full;
  logic [NUM_REQS-1:0]      overflow;
  logic                     blk;
  logic [NUM_REQS-1:0]      reqs;
  logic [NUM_REQS-1:0]      gnt;
  logic                     out_valid;
  logic [DWID-1:0]          out_data;
  logic [CNTWID-1:0]        out_src;
  logic                     gnt_err;

  modport slave (
    input  push, push_data, blk, gnt,
    output full, overflow, reqs, out_valid, out_data, out_src, gnt_err
  );
  modport master (
    output push, push_data, blk, gnt,
    input  full, overflow, reqs, out_valid, out_data, out_src, gnt_err
  );
endinterface

// File: rtl/dwrr_req_queues.sv
// Per-source packet FIFOs feeding a DWRR arbiter; the granted FIFO is popped
// onto one registered output stream.

module dwrr_req_fifo #(
  parameter int DWID  = 8,
  parameter int DEPTH = 4,
  parameter int AWID  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [DWID-1:0] push_data,
  input  logic            pop,
  output logic [DWID-1:0] head,
  output logic            reqs,
  output logic            full,
  output logic            overflow
);
  logic [DWID-1:0] mem [DEPTH];
  logic [AWID-1:0] wr_ptr, rd_ptr;
  logic [AWID:0]   count;
  logic            push_ok;

  // reqs/full come straight from the count register so no combinational
  // path exists from push/gnt back into the arbiter.
  assign full    = (count == (AWID+1)'(DEPTH));
  assign reqs    = (count != '0);
  assign push_ok = push && !full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AWID{1'b0}}, push_ok} - {{AWID{1'b0}}, pop};
      if (push && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

module dwrr_req_queues #(
  parameter int NUM_REQS = 4,
  parameter int DWID     = 8,
  parameter int DEPTH    = 4,
  parameter int AWID     = $clog2(DEPTH),
  parameter int CNTWID   = $clog2(NUM_REQS)
) (
  input logic             clk,
  input logic             rst,
  dwrr_req_queues_if.slave bus
);
  logic [NUM_REQS-1:0]           reqs_v, full_v, ovf_v, pop;
  logic [NUM_REQS-1:0][DWID-1:0] head;
  logic [NUM_REQS-1:0]           gnt_m1;
  logic                          one_hot, legal;
  logic [CNTWID-1:0]             g_idx;

  genvar i;
  generate
    for (i = 0; i < NUM_REQS; i++) begin : g_q
      dwrr_req_fifo #(.DWID(DWID), .DEPTH(DEPTH), .AWID(AWID)) u_q (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.push[i]),
        .push_data(bus.push_data[i*DWID +: DWID]),
        .pop      (pop[i]),
        .head     (head[i]),
        .reqs     (reqs_v[i]),
        .full     (full_v[i]),
        .overflow (ovf_v[i])
      );
    end
  endgenerate

  assign bus.reqs     = reqs_v;
  assign bus.full     = full_v;
  assign bus.overflow = ovf_v;

  // A grant is honoured only if it is one-hot and lands on a non-empty queue.
  always_comb begin
    gnt_m1  = bus.gnt - 1'b1;
    one_hot = (bus.gnt != '0) && ((bus.gnt & gnt_m1) == '0);
    legal   = one_hot && ((bus.gnt & reqs_v) != '0);
    g_idx   = '0;
    for (int k = 0; k < NUM_REQS; k++)
      if (bus.gnt[k]) g_idx = CNTWID'(k);
    pop = (legal && !bus.blk) ? bus.gnt : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      bus.gnt_err   <= 1'b0;
    end else begin
      bus.out_valid <= |pop;
      if (|pop) begin
        bus.out_data <= head[g_idx];
        bus.out_src  <= g_idx;
      end
      bus.gnt_err <= !bus.blk && (bus.gnt != '0) && !legal;
    end
  end
endmodule

// File: doc/dwrr_req_queues.md
Name: dwrr_req_queues

Overview:
- Requestor-side companion to the DWRR arbiter: NUM_REQS per-source packet FIFOs that raise `reqs` to the arbiter when non-empty.
- Consumes the arbiter's one-hot `gnt`, pops the granted FIFO and forwards the packet on a single registered output stream.
- Sits between the source ports and the arbiter; `reqs`/`gnt`/`blk` connect directly to the arbiter's ports.

Parameters:
- NUM_REQS, 4, number of source queues; must match the arbiter.
- DWID, 8, packet data width.
- DEPTH, 4, entries per FIFO; power of two, >= 2.
- AWID, $clog2(DEPTH), FIFO pointer width.
- CNTWID, $clog2(NUM_REQS), source index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset.
- push  input  NUM_REQS  per-source write strobe.
- push_data  input  NUM_REQS*DWID  per-source data; source i in bits [(i+1)*DWID-1:i*DWID].
- full  output  NUM_REQS  queue i holds DEPTH entries (registered).
- overflow  output  NUM_REQS  sticky: push to a full queue was dropped.
- blk  input  1  downstream stall; shared with the arbiter's blk.
- reqs  output  NUM_REQS  queue i non-empty; to arbiter reqs.
- gnt  input  NUM_REQS  grant from arbiter; one-hot or zero.
- out_valid  output  1  packet valid this cycle.
- out_data  output  DWID  packet data.
- out_src  output  CNTWID  index of the source that supplied out_data.
- gnt_err  output  1  one-cycle pulse on an illegal grant.

Behaviour:
- Reset (rst==0 at clock edge):
  - All counts, read and write pointers, out_valid, out_data, out_src, gnt_err and overflow go to 0.
  - full=0 and reqs=0 the cycle after reset.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-transfer discards all queued data.
- Per-queue state: wr_ptr, rd_ptr (AWID bits, wrap mod DEPTH) and count (AWID+1 bits, range 0..DEPTH).
- reqs[i] = (count[i] != 0).
  - Derived from registers only; no combinational path from push or gnt to reqs. This avoids a loop through the arbiter's combinational gnt.
  - reqs is not gated by blk.
- full[i] = (count[i] == DEPTH).
- Push:
  - Accepted when push[i] && !full[i]; writes mem[wr_ptr] and increments wr_ptr.
  - Push while full is dropped, even if the same queue pops that cycle; sets overflow[i] until reset.
- Legal grant: gnt has exactly one bit set, at index g, with reqs[g]==1.
- Pop: legal grant && !blk.
  - Reads mem[rd_ptr[g]] and increments rd_ptr[g].
  - Next cycle: out_valid=1, out_data=popped entry, out_src=g. Latency is 1 cycle from grant edge to output.
- No pop: out_valid=0 next cycle; out_data and out_src hold their previous values.
- blk==1: no pop and no gnt_err evaluation; queues hold; pushes are still accepted.
- Illegal grant (more than one bit set, or gnt[i] with reqs[i]==0) while !blk:
  - No pop; gnt_err=1 for exactly the next cycle.
  - Arbiter state is not this block's concern.
- Simultaneous push and pop on the same non-full queue: count unchanged, both pointers advance. The popped data is the old head; a push to an empty queue is not bypassed to the output that cycle.
- Count update: count + (push_ok) - (pop), computed in AWID+1 bits; never wraps.
- Throughput: one packet per cycle maximum, across all queues.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with push=4'b1111 -> after release all reqs=0, full=0, out_valid=0, overflow=0.
- Single source: push 0x11, 0x22 into q2, drive gnt=4'b0100 for 2 cycles -> out_valid high on following 2 cycles, out_data 0x11 then 0x22, out_src=2; reqs[2] drops after second pop.
- Fill and overflow: 5 pushes to q0 (DEPTH=4) with no gnt -> full[0]=1 after 4th, 5th dropped, overflow[0]=1 sticky; drain yields exactly 4 entries in order.
- Blk stall: q1 holds 0xA5, gnt=4'b0010 with blk=1 for 3 cycles -> out_valid=0, count unchanged; blk=0 -> 0xA5 out next cycle.
- Illegal grants: gnt=4'b0011 with both queues non-empty, then gnt=4'b1000 with q3 empty -> gnt_err pulses 1 cycle each, no data popped, out_valid=0.
- Concurrent push/pop plus wrap: q3 kept at count 2 with push and gnt every cycle for 10 cycles -> output sequence matches push order, count stays 2, pointers wrap cleanly.
